// File: rtl/fractal_pkg.sv
// Shared types and constants for the time-interleaved escape-time engine.
// FRACTAL_ESCAPE_MAG_EN adds the final |z|^2 to each slot for smooth colouring.
package fractal_pkg;

    localparam int INTEGER_BITS    = 8;
    localparam int FRACTIONAL_BITS = 24;
    localparam int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS;
    localparam int MAX_ITER_WIDTH  = 16;
    localparam int TAG_WIDTH       = 8;

    typedef enum logic {
        MODE_JULIA  = 1'b0,
        MODE_MANDEL = 1'b1
    } mode_e;

    // 4.0 in Q format, one bit wider than an operand to hold x^2+y^2
    localparam logic signed [DATA_WIDTH:0] ESC_THRESHOLD =
        (DATA_WIDTH+1)'(4) <<< FRACTIONAL_BITS;

    typedef struct packed {
        logic                             valid;
        logic                             done;
        logic signed [DATA_WIDTH-1:0]     x;
        logic signed [DATA_WIDTH-1:0]     y;
        logic signed [DATA_WIDTH-1:0]     cx;
        logic signed [DATA_WIDTH-1:0]     cy;
        logic        [MAX_ITER_WIDTH-1:0] iter;
        logic        [MAX_ITER_WIDTH-1:0] max_iter;
        logic        [TAG_WIDTH-1:0]      tag;
`ifdef FRACTAL_ESCAPE_MAG_EN
        logic signed [DATA_WIDTH:0]       mag;
`endif
    } slot_t;

endpackage

// File: rtl/fractal_core_mt_qmul_pipe.sv
// Signed Q-format multiplier: full-width product, arithmetic truncation,
// followed by STAGES enable-gated registers so the ring can freeze on stall.
module qmul_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int FRACTIONAL_BITS = 24,
    parameter int STAGES          = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] p_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [DATA_WIDTH-1:0]   pipe_q [STAGES];

    assign prod = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < STAGES; i++) pipe_q[i] <= '0;
        end else if (en_i) begin
            pipe_q[0] <= DATA_WIDTH'(prod >>> FRACTIONAL_BITS);
            for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign p_o = pipe_q[STAGES-1];

endmodule

// File: rtl/fractal_core_mt.sv
// Multi-context Julia/Mandelbrot escape-time core; slot widths come from fractal_pkg.
// Optional output mag_o is enabled by defining FRACTAL_ESCAPE_MAG_EN.
module fractal_core_mt
    import fractal_pkg::*;
#(
    parameter int INTEGER_BITS    = fractal_pkg::INTEGER_BITS,
    parameter int FRACTIONAL_BITS = fractal_pkg::FRACTIONAL_BITS,
    parameter int DATA_WIDTH      = INTEGER_BITS + FRACTIONAL_BITS,
    parameter int MAX_ITER_WIDTH  = fractal_pkg::MAX_ITER_WIDTH,
    parameter int MULT_STAGES     = 2,
    parameter int TAG_WIDTH       = fractal_pkg::TAG_WIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic                         mode_i,
    input  logic signed [DATA_WIDTH-1:0] px_i,
    input  logic signed [DATA_WIDTH-1:0] py_i,
    input  logic signed [DATA_WIDTH-1:0] cx_i,
    input  logic signed [DATA_WIDTH-1:0] cy_i,
    input  logic [MAX_ITER_WIDTH-1:0]    max_iter_i,
    input  logic [TAG_WIDTH-1:0]         tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [MAX_ITER_WIDTH-1:0]    iter_o,
`ifdef FRACTAL_ESCAPE_MAG_EN
    output logic signed [DATA_WIDTH:0]   mag_o,
`endif
    output logic [TAG_WIDTH-1:0]         tag_o
);

    localparam int L = MULT_STAGES + 1;

    slot_t slot_q [L];
    slot_t head_d;
    slot_t tail_d;
    logic  free_head;
    logic  advance;

    logic signed [DATA_WIDTH-1:0] mul_a [3];
    logic signed [DATA_WIDTH-1:0] mul_b [3];
    logic signed [DATA_WIDTH-1:0] mul_p [3];
    logic signed [DATA_WIDTH:0]   mag;

    // A completed result waiting on the consumer freezes the whole ring and
    // the multiplier pipes together, which keeps the presented result steady.
    assign free_head  = !slot_q[0].valid || (slot_q[0].done && out_ready_i);
    assign advance    = !(slot_q[0].valid && slot_q[0].done && !out_ready_i);
    assign in_ready_o = free_head;

    always_comb begin
        head_d = slot_q[0];
        if (free_head) begin
            head_d = '0;
            if (in_valid_i) begin
                head_d.valid    = 1'b1;
                head_d.max_iter = max_iter_i;
                head_d.tag      = tag_i;
                if (mode_e'(mode_i) == MODE_MANDEL) begin
                    head_d.cx = px_i;
                    head_d.cy = py_i;
                end else begin
                    head_d.x  = px_i;
                    head_d.y  = py_i;
                    head_d.cx = cx_i;
                    head_d.cy = cy_i;
                end
            end
        end
    end

    assign mul_a = '{head_d.x, head_d.y, head_d.x};
    assign mul_b = '{head_d.x, head_d.y, head_d.y};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mul
            qmul_pipe #(
                .DATA_WIDTH      (DATA_WIDTH),
                .FRACTIONAL_BITS (FRACTIONAL_BITS),
                .STAGES          (MULT_STAGES)
            ) u_qmul (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (advance),
                .a_i   (mul_a[gi]),
                .b_i   (mul_b[gi]),
                .p_o   (mul_p[gi])
            );
        end
    endgenerate

    // mul_p: [0]=x^2, [1]=y^2, [2]=xy, aligned with the last ring position
    assign mag = {mul_p[0][DATA_WIDTH-1], mul_p[0]} + {mul_p[1][DATA_WIDTH-1], mul_p[1]};

    always_comb begin
        tail_d = slot_q[L-1];
        if (slot_q[L-1].valid && !slot_q[L-1].done) begin
            if ((mag > ESC_THRESHOLD) || (slot_q[L-1].iter >= slot_q[L-1].max_iter)) begin
                tail_d.done = 1'b1;
`ifdef FRACTAL_ESCAPE_MAG_EN
                tail_d.mag  = mag;
`endif
            end else begin
                tail_d.x    = mul_p[0] - mul_p[1] + slot_q[L-1].cx;
                tail_d.y    = (mul_p[2] <<< 1) + slot_q[L-1].cy;
                tail_d.iter = slot_q[L-1].iter + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < L; i++) slot_q[i] <= '0;
        end else if (advance) begin
            slot_q[0] <= tail_d;
            slot_q[1] <= head_d;
            for (int i = 2; i < L; i++) slot_q[i] <= slot_q[i-1];
        end
    end

    assign out_valid_o = slot_q[0].valid && slot_q[0].done;
    assign iter_o      = out_valid_o ? slot_q[0].iter : '0;
    assign tag_o       = out_valid_o ? slot_q[0].tag  : '0;
`ifdef FRACTAL_ESCAPE_MAG_EN
    assign mag_o       = out_valid_o ? slot_q[0].mag  : '0;
`endif

endmodule

// File: tb/tb_fractal_core_mt.sv
// Self-checking bench for fractal_core_mt: directed escape cases, stall, reset,
// and a randomized mixed-mode stream scored against an arithmetic reference model.
module tb_fractal_core_mt;

    localparam int DW = 32;
    localparam int F  = 24;
    localparam int IW = 16;
    localparam int TW = 8;
    localparam int MS = 2;
    localparam int L  = MS + 1;
    localparam int NPIX = 64;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic signed [DW-1:0] px, py, cx, cy;
    logic [IW-1:0]        max_iter;
    logic [TW-1:0]        tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [IW-1:0]        iter_out;
    logic [TW-1:0]        tag_out;
`ifdef FRACTAL_ESCAPE_MAG_EN
    logic signed [DW:0]   mag_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fractal_core_mt #(.MULT_STAGES(MS)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .mode_i      (mode),
        .px_i        (px),
        .py_i        (py),
        .cx_i        (cx),
        .cy_i        (cy),
        .max_iter_i  (max_iter),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .iter_o      (iter_out),
`ifdef FRACTAL_ESCAPE_MAG_EN
        .mag_o       (mag_out),
`endif
        .tag_o       (tag_out)
    );

    // ---------------- reference model ----------------
    function automatic longint wrap32(input longint v);
        logic signed [31:0] t;
        t = v[31:0];
        return t;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return wrap32((a * b) >>> F);
    endfunction

    function automatic int ref_iter(input bit mandel, input longint ppx, input longint ppy,
                                    input longint ccx, input longint ccy, input int maxi);
        longint zx, zy, ax, ay, x2, y2, xy;
        int n;
        zx = mandel ? 0 : ppx;
        zy = mandel ? 0 : ppy;
        ax = mandel ? ppx : ccx;
        ay = mandel ? ppy : ccy;
        n  = 0;
        forever begin
            x2 = qmul(zx, zx);
            y2 = qmul(zy, zy);
            xy = qmul(zx, zy);
            if (x2 + y2 > (longint'(4) << F)) return n;
            if (n >= maxi) return n;
            zx = wrap32(x2 - y2 + ax);
            zy = wrap32(2 * xy + ay);
            n++;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic send(input bit m, input logic signed [DW-1:0] ppx, input logic signed [DW-1:0] ppy,
                        input logic signed [DW-1:0] ccx, input logic signed [DW-1:0] ccy,
                        input int mi, input int tg, output bit ok);
        mode = m; px = ppx; py = ppy; cx = ccx; cy = ccy;
        max_iter = IW'(mi); tag = TW'(tg); in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cnt, output bit ok);
        cnt = 1;
        ok  = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        mode = 1'b0; px = '0; py = '0; cx = '0; cy = '0; max_iter = '0; tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (iter_out !== '0) begin failures++; $display("FAIL reset_iter got=%0d exp=0", iter_out); end
        checks++; if (tag_out !== '0) begin failures++; $display("FAIL reset_tag got=%0d exp=0", tag_out); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        $display("test_reset done");
    endtask

    task automatic test_julia_fixed();
        bit ok, ok2; int cnt;
        out_ready = 1'b1;
        send(1'b0, 0, 0, 0, 0, 10, 8'h11, ok);
        wait_out(cnt, ok2);
        checks++; if (!(ok && ok2)) begin failures++; $display("FAIL julia_fixed_timeout accepted=%0b seen=%0b exp=1/1", ok, ok2); end
        checks++; if (cnt != 11 * L) begin failures++; $display("FAIL julia_fixed_latency got=%0d exp=%0d", cnt, 11 * L); end
        checks++; if (iter_out !== 16'd10) begin failures++; $display("FAIL julia_fixed_iter got=%0d exp=10", iter_out); end
        checks++; if (tag_out !== 8'h11) begin failures++; $display("FAIL julia_fixed_tag got=%0h exp=11", tag_out); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL julia_fixed_retire got=%0b exp=0", out_valid); end
        $display("test_julia_fixed tag=11 iter=%0d latency=%0d", iter_out, cnt);
    endtask

    task automatic test_boundary();
        bit ok, ok2; int cnt;
        out_ready = 1'b1;
        send(1'b0, 32'sh0200_0000, 0, 0, 0, 50, 8'h22, ok);
        wait_out(cnt, ok2);
        checks++; if (!(ok && ok2)) begin failures++; $display("FAIL boundary_timeout accepted=%0b seen=%0b exp=1/1", ok, ok2); end
        checks++; if (cnt != 2 * L) begin failures++; $display("FAIL boundary_latency got=%0d exp=%0d", cnt, 2 * L); end
        checks++; if (iter_out !== 16'd1) begin failures++; $display("FAIL boundary_iter got=%0d exp=1", iter_out); end
`ifdef FRACTAL_ESCAPE_MAG_EN
        checks++; if (mag_out !== 33'sh1000_0000) begin failures++; $display("FAIL boundary_mag got=%0h exp=10000000", mag_out); end
`endif
        @(posedge clk); #1;
        $display("test_boundary tag=22 iter=%0d latency=%0d", iter_out, cnt);
    endtask

    task automatic test_escape_cases();
        bit                   tm [3] = '{1'b1, 1'b0, 1'b0};
        logic signed [DW-1:0] tx [3] = '{32'sh0280_0000, 32'sh0300_0000, 32'sh0080_0000};
        int                   tmi[3] = '{100, 50, 0};
        int                   texp[3] = '{1, 0, 0};
        bit ok, ok2; int cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(tm[i], tx[i], 0, 0, 0, tmi[i], 8'h30 + i, ok);
            wait_out(cnt, ok2);
            checks++; if (!(ok && ok2)) begin failures++; $display("FAIL escape%0d_timeout accepted=%0b seen=%0b exp=1/1", i, ok, ok2); end
            checks++; if (iter_out !== IW'(texp[i])) begin failures++; $display("FAIL escape%0d_iter got=%0d exp=%0d", i, iter_out, texp[i]); end
            checks++; if (cnt != (texp[i] + 1) * L) begin failures++; $display("FAIL escape%0d_latency got=%0d exp=%0d", i, cnt, (texp[i] + 1) * L); end
            checks++; if (tag_out !== TW'(8'h30 + i)) begin failures++; $display("FAIL escape%0d_tag got=%0h exp=%0h", i, tag_out, 8'h30 + i); end
            $display("test_escape case=%0d iter=%0d latency=%0d", i, iter_out, cnt);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_fill();
        bit ok, ok2; int cnt;
        int seen [L+1];
        int total;
        out_ready = 1'b0;
        for (int t = 1; t <= L; t++) begin
            send(1'b0, 0, 0, 0, 0, 5, t, ok);
            checks++; if (!ok) begin failures++; $display("FAIL stall_fill_accept tag=%0d got=0 exp=1", t); end
        end
        wait_out(cnt, ok2);
        checks++; if (!ok2) begin failures++; $display("FAIL stall_first_done got=0 exp=1"); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, tag_out, iter_out} !== {1'b1, 1'b0, 8'd1, 16'd5}) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got v=%0b rdy=%0b tag=%0d iter=%0d exp v=1 rdy=0 tag=1 iter=5",
                         c, out_valid, in_ready, tag_out, iter_out);
            end
        end
        @(posedge clk); #1 out_ready = 1'b1;
        for (int i = 0; i <= L; i++) seen[i] = 0;
        total = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (tag_out >= 1 && tag_out <= L) seen[tag_out]++;
                $display("stall_release retire tag=%0d iter=%0d", tag_out, iter_out);
            end
        end
        checks++; if (total != L) begin failures++; $display("FAIL stall_release_count got=%0d exp=%0d", total, L); end
        for (int t = 1; t <= L; t++) begin
            checks++; if (seen[t] != 1) begin failures++; $display("FAIL stall_release_tag%0d got=%0d exp=1", t, seen[t]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit                   pm  [NPIX];
        logic signed [DW-1:0] ppx [NPIX], ppy [NPIX], pcx [NPIX], pcy [NPIX];
        int                   pmi [NPIX], pexp [NPIX], pseen [NPIX];
        int idx, got;
        bit acc, prev_stall;
        logic [TW-1:0] prev_tag;
        logic [IW-1:0] prev_iter;
        for (int i = 0; i < NPIX; i++) begin
            pm[i]  = 1'($urandom_range(0, 1));
            ppx[i] = DW'(int'($urandom_range(0, 83886080)) - 41943040);
            ppy[i] = DW'(int'($urandom_range(0, 83886080)) - 41943040);
            pcx[i] = DW'(int'($urandom_range(0, 33554432)) - 16777216);
            pcy[i] = DW'(int'($urandom_range(0, 33554432)) - 16777216);
            pmi[i] = int'($urandom_range(0, 20));
            pexp[i] = ref_iter(pm[i], ppx[i], ppy[i], pcx[i], pcy[i], pmi[i]);
            pseen[i] = 0;
        end
        idx = 0; got = 0; prev_stall = 1'b0; prev_tag = '0; prev_iter = '0;
        for (int cyc = 0; cyc < 20000 && got < NPIX; cyc++) begin
            if (idx < NPIX) begin
                in_valid = 1'b1; mode = pm[idx]; px = ppx[idx]; py = ppy[idx];
                cx = pcx[idx]; cy = pcy[idx]; max_iter = IW'(pmi[idx]); tag = TW'(idx);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (prev_stall) begin
                checks++;
                if ({out_valid, tag_out, iter_out} !== {1'b1, prev_tag, prev_iter}) begin
                    failures++;
                    $display("FAIL b2b_stall_stable got v=%0b tag=%0d iter=%0d exp v=1 tag=%0d iter=%0d",
                             out_valid, tag_out, iter_out, prev_tag, prev_iter);
                end
            end
            if (out_valid && out_ready) begin
                got++;
                checks++;
                if (tag_out >= NPIX || pseen[tag_out] != 0) begin
                    failures++;
                    $display("FAIL b2b_tag got=%0d exp=unseen_tag_below_%0d", tag_out, NPIX);
                end else begin
                    pseen[tag_out] = 1;
                    if (iter_out !== IW'(pexp[tag_out])) begin
                        failures++;
                        $display("FAIL b2b_iter tag=%0d got=%0d exp=%0d", tag_out, iter_out, pexp[tag_out]);
                    end else begin
                        $display("b2b retire tag=%0d iter=%0d", tag_out, iter_out);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_tag   = tag_out;
            prev_iter  = iter_out;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (got != NPIX) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got, NPIX); end
    endtask

    task automatic test_mid_reset();
        bit ok; bit stale;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) send(1'b0, 0, 0, 0, 0, 30, 8'hA0 + t, ok);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%0b exp=0", out_valid); end
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready got=%0b exp=1", in_ready); end
        stale = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checks++; if (stale) begin failures++; $display("FAIL midreset_stale got=1 exp=0"); end
        $display("test_mid_reset stale=%0b", stale);
    endtask

    initial begin
        test_reset();
        test_julia_fixed();
        test_boundary();
        test_escape_cases();
        test_stall_fill();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
